// File: rtl/fa4_sweep_gen.sv
// Operand sequencer and optional result checker for the 4-bit ripple adder fulladd4.
// Optional checker is built when FA4_SWEEP_CHECK_EN is defined.
module fa4_sweep_gen #(
  parameter int unsigned HOLD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a_lo,
  input  logic [3:0] a_hi,
  input  logic [1:0] cin_mode,
  input  logic [3:0] s,
  input  logic       cout,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       Cin,
  output logic       vld,
  output logic       busy,
  output logic       done,
  output logic [9:0] vec_cnt,
  output logic [7:0] err_cnt,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

  state_t     state, state_n;
  logic [3:0] a_hi_r;
  logic [1:0] mode_r;
  logic [3:0] hcnt;
  logic       pair;
  logic       last_hold;
  logic       last_vec;
  logic       accept;
  logic       range_ok;

  assign pair      = (mode_r == 2'b10);
  assign last_hold = (hcnt == HOLD_M1);
  // Terminal test is done on the current vector so a_hi=15 never wraps a to 0.
  assign last_vec  = (a == a_hi_r) && (b == 4'hf) && (!pair || Cin);
  assign accept    = (state == IDLE) && start;
  assign range_ok  = (a_lo <= a_hi);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    vld     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: if (start) state_n = range_ok ? RUN : DONE;
      RUN: begin
        vld  = 1'b1;
        busy = 1'b1;
        if (last_hold && last_vec) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a       <= '0;
      b       <= '0;
      Cin     <= 1'b0;
      a_hi_r  <= '0;
      mode_r  <= '0;
      hcnt    <= '0;
      vec_cnt <= '0;
    end else if (accept) begin
      a_hi_r  <= a_hi;
      mode_r  <= cin_mode;
      hcnt    <= '0;
      vec_cnt <= range_ok ? 10'd1 : 10'd0;
      if (range_ok) begin
        a   <= a_lo;
        b   <= '0;
        Cin <= (cin_mode == 2'b01);
      end
    end else if (state == RUN) begin
      if (!last_hold) begin
        hcnt <= hcnt + 4'd1;
      end else begin
        hcnt <= '0;
        if (!last_vec) begin
          vec_cnt <= vec_cnt + 10'd1;
          if (pair && !Cin) begin
            Cin <= 1'b1;
          end else begin
            Cin <= (mode_r == 2'b01);
            if (b == 4'hf) begin
              b <= '0;
              a <= a + 4'd1;
            end else begin
              b <= b + 4'd1;
            end
          end
        end
      end
    end
  end

`ifdef FA4_SWEEP_CHECK_EN
  logic [4:0] expect_sum;
  assign expect_sum = {1'b0, a} + {1'b0, b} + {4'b0, Cin};

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
      err     <= 1'b0;
    end else if (accept) begin
      err_cnt <= '0;
      err     <= 1'b0;
    end else if ((state == RUN) && last_hold && ({cout, s} != expect_sum)) begin
      if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
      err <= 1'b1;
    end
  end
`else
  logic unused_adder;
  assign unused_adder = ^{s, cout};
  assign err_cnt = '0;
  assign err     = 1'b0;
`endif

endmodule
